// File: rtl/irq_mmio_ctrl_if.sv
// ============================================================================
// irq_mmio_ctrl_if : CPU-side bus and interrupt handshake of irq_mmio_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface irq_mmio_ctrl_if #(
   parameter int NUM_IRQ = 4,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 12
);
   localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wr_data;
   logic              memwrt;
   logic              intack;
   logic [DATA_W-1:0] rd_data;
   logic              reg_hit;
   logic              int_req;
   logic [ID_W-1:0]   int_id;
   logic [ADDR_W-1:0] vec_addr;

   modport master (
      output address, wr_data, memwrt, intack,
      input  rd_data, reg_hit, int_req, int_id, vec_addr
   );

   modport slave (
      input  address, wr_data, memwrt, intack,
      output rd_data, reg_hit, int_req, int_id, vec_addr
   );
endinterface

`default_nettype wire

// File: rtl/irq_mmio_ctrl.sv
// ============================================================================
// irq_mmio_ctrl : N-channel edge-latched interrupt controller, MMIO registers
// Rev 1.0
// ============================================================================
`default_nettype none

module irq_mmio_ctrl #(
   parameter int                     NUM_IRQ  = 4,
   parameter int                     DATA_W   = 16,
   parameter int                     ADDR_W   = 12,
   parameter logic [ADDR_W-1:0]      VEC_BASE = 12'hBBB,
   parameter logic [ADDR_W-1:0]      REG_BASE = 12'h0F8,
   parameter logic [NUM_IRQ-1:0]     MASK_RST = '1
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic [NUM_IRQ-1:0] irq_src,
   irq_mmio_ctrl_if.slave          bus
);
   localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_SERVICE = 2'd2;

   localparam logic [1:0] OFF_STATUS = 2'd0;
   localparam logic [1:0] OFF_MASK   = 2'd1;
   localparam logic [1:0] OFF_SWTRIG = 2'd2;
   localparam logic [1:0] OFF_EOI    = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] prev_q;
   logic [ID_W-1:0]    int_id_q, int_id_d;

   logic [ADDR_W-1:0]  offset;
   logic               hit;
   logic               wr_mask, wr_swtrig, wr_eoi;
   logic [NUM_IRQ-1:0] evt;
   logic [NUM_IRQ-1:0] enabled;
   logic [ID_W-1:0]    winner;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] sw_set;
   logic               int_req, in_service, ack, id_load;

   // ---------------------------------------------------------------- decode
   assign offset    = bus.address - REG_BASE;
   assign hit       = (offset < ADDR_W'(4));
   assign wr_mask   = bus.memwrt && hit && (offset[1:0] == OFF_MASK);
   assign wr_swtrig = bus.memwrt && hit && (offset[1:0] == OFF_SWTRIG);
   assign wr_eoi    = bus.memwrt && hit && (offset[1:0] == OFF_EOI);

   assign evt     = irq_src & ~prev_q;
   assign enabled = pending_q & mask_q;

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (enabled[i]) winner = ID_W'(i);
      end
   end

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (|enabled)  state_d = S_REQ;
         S_REQ:     if (bus.intack) state_d = S_SERVICE;
         S_SERVICE: if (wr_eoi)     state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      int_req    = (state_q == S_REQ);
      in_service = (state_q == S_SERVICE);
      ack        = int_req && bus.intack;
      id_load    = (state_q == S_IDLE) && (|enabled);
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      ack_clr = '0;
      if (ack) ack_clr[int_id_q] = 1'b1;
      sw_set = wr_swtrig ? bus.wr_data[NUM_IRQ-1:0] : '0;
      // Sets are applied after the acknowledge clear so a coincident event survives.
      pending_d = (pending_q & ~ack_clr) | evt | sw_set;
      mask_d    = wr_mask ? bus.wr_data[NUM_IRQ-1:0] : mask_q;
      int_id_d  = id_load ? winner : int_id_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         mask_q    <= MASK_RST;
         prev_q    <= '0;
         int_id_q  <= '0;
      end else begin
         pending_q <= pending_d;
         mask_q    <= mask_d;
         prev_q    <= irq_src;
         int_id_q  <= int_id_d;
      end
   end

   // ------------------------------------------------------------ read mux
   always_comb begin
      bus.rd_data = '0;
      if (hit) begin
         case (offset[1:0])
            OFF_STATUS: bus.rd_data = DATA_W'(pending_q);
            OFF_MASK:   bus.rd_data = DATA_W'(mask_q);
            OFF_SWTRIG: bus.rd_data = '0;
            OFF_EOI: begin
               bus.rd_data[ID_W-1:0]   = int_id_q;
               bus.rd_data[DATA_W-1]   = in_service;
            end
            default:    bus.rd_data = '0;
         endcase
      end
   end

   assign bus.reg_hit  = hit;
   assign bus.int_req  = int_req;
   assign bus.int_id   = int_id_q;
   assign bus.vec_addr = VEC_BASE + ADDR_W'(int_id_q);

endmodule

`default_nettype wire

// File: tb/tb_irq_mmio_ctrl.sv
// ============================================================================
// tb_irq_mmio_ctrl : directed self-checking bench for irq_mmio_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_irq_mmio_ctrl;
   localparam int          NUM_IRQ  = 4;
   localparam int          DATA_W   = 16;
   localparam int          ADDR_W   = 12;
   localparam logic [11:0] REG_BASE = 12'h0F8;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_IRQ-1:0] irq_src;
   int                 n_cmp = 0;
   int                 n_err = 0;

   irq_mmio_ctrl_if #(.NUM_IRQ(NUM_IRQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   irq_mmio_ctrl #(
      .NUM_IRQ (NUM_IRQ),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .VEC_BASE(12'hBBB),
      .REG_BASE(REG_BASE),
      .MASK_RST(4'hF)
   ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .irq_src(irq_src),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_write(input logic [1:0] off, input logic [15:0] data);
      bus.address = REG_BASE + 12'(off);
      bus.wr_data = data;
      bus.memwrt  = 1'b1;
      step();
      bus.memwrt  = 1'b0;
      bus.address = '0;
      bus.wr_data = '0;
   endtask

   task automatic reg_read(input logic [1:0] off, output logic [15:0] data);
      bus.address = REG_BASE + 12'(off);
      #1;
      data = bus.rd_data;
      bus.address = '0;
   endtask

   task automatic ack();
      bus.intack = 1'b1;
      step();
      bus.intack = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] src);
      irq_src = src;
      step();
      irq_src = '0;
   endtask

   logic [15:0] rd;

   initial begin
      reset = 1'b1; irq_src = '0;
      bus.address = '0; bus.wr_data = '0; bus.memwrt = 1'b0; bus.intack = 1'b0;
      step(); step();
      reset = 1'b0;

      // Reset state and window decode
      chk("rst_int_req", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("rst_status", 32'(rd), 32'h0);
      reg_read(2'd1, rd); chk("rst_mask", 32'(rd), 32'hF);
      reg_read(2'd3, rd); chk("rst_eoi_rd", 32'(rd), 32'h0);
      bus.address = 12'h0FC; #1;
      chk("miss_hit", 32'(bus.reg_hit), 32'd0);
      chk("miss_rd", 32'(bus.rd_data), 32'd0);
      bus.address = 12'h0F8; #1;
      chk("base_hit", 32'(bus.reg_hit), 32'd1);
      bus.address = '0;

      // 1: single event on source 2
      pulse(4'b0100);
      reg_read(2'd0, rd); chk("t1_status", 32'(rd), 32'h4);
      chk("t1_no_req_yet", 32'(bus.int_req), 32'd0);
      step();
      chk("t1_req", 32'(bus.int_req), 32'd1);
      chk("t1_id", 32'(bus.int_id), 32'd2);
      chk("t1_vec", 32'(bus.vec_addr), 32'hBBD);
      bus.intack = 1'b1; #1;
      chk("t1_vec_ack", 32'(bus.vec_addr), 32'hBBD);
      step(); bus.intack = 1'b0;
      chk("t1_req_drop", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t1_status_clr", 32'(rd), 32'h0);
      reg_read(2'd3, rd); chk("t1_eoi_rd_svc", 32'(rd), 32'h8002);
      reg_write(2'd3, 16'h0);
      reg_read(2'd3, rd); chk("t1_eoi_rd_idle", 32'(rd), 32'h0002);

      // 2: priority between sources 3 and 1
      pulse(4'b1010);
      step();
      chk("t2_id_first", 32'(bus.int_id), 32'd1);
      ack();
      reg_write(2'd3, 16'h0);
      chk("t2_idle_after_eoi", 32'(bus.int_req), 32'd0);
      step();
      chk("t2_req2", 32'(bus.int_req), 32'd1);
      chk("t2_id_second", 32'(bus.int_id), 32'd3);
      chk("t2_vec_second", 32'(bus.vec_addr), 32'hBBE);
      ack();
      reg_write(2'd3, 16'h0);

      // 3: mask
      reg_write(2'd1, 16'hFFFE);
      reg_read(2'd1, rd); chk("t3_mask_rd", 32'(rd), 32'h000E);
      pulse(4'b0001);
      step();
      chk("t3_masked_req", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t3_status", 32'(rd), 32'h1);
      reg_write(2'd1, 16'h000F);
      chk("t3_old_mask_eval", 32'(bus.int_req), 32'd0);
      step();
      chk("t3_req", 32'(bus.int_req), 32'd1);
      chk("t3_id", 32'(bus.int_id), 32'd0);

      // 4: event coincident with intack, then events during service
      irq_src = 4'b0001; bus.intack = 1'b1;
      step();
      irq_src = '0; bus.intack = 1'b0;
      chk("t4_svc_req", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t4_set_wins", 32'(rd), 32'h1);
      pulse(4'b0001);
      step(); step();
      chk("t4_no_req_svc", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t4_pending_svc", 32'(rd), 32'h1);
      reg_write(2'd3, 16'hFFFF);
      chk("t4_idle", 32'(bus.int_req), 32'd0);
      step();
      chk("t4_rereq", 32'(bus.int_req), 32'd1);
      chk("t4_rereq_id", 32'(bus.int_id), 32'd0);
      ack();
      reg_write(2'd3, 16'h0);

      // 5: software trigger, then a held level
      reg_write(2'd2, 16'h0008);
      reg_read(2'd2, rd); chk("t5_swtrig_rd", 32'(rd), 32'h0);
      step();
      chk("t5_sw_req", 32'(bus.int_req), 32'd1);
      chk("t5_sw_id", 32'(bus.int_id), 32'd3);
      ack();
      reg_write(2'd3, 16'h0);
      irq_src = 4'b0010;
      step();
      reg_read(2'd0, rd); chk("t5_level_set", 32'(rd), 32'h2);
      step();
      chk("t5_level_id", 32'(bus.int_id), 32'd1);
      ack();
      reg_write(2'd3, 16'h0);
      for (int i = 0; i < 6; i++) step();
      chk("t5_level_once_req", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t5_level_once_pend", 32'(rd), 32'h0);
      irq_src = '0;
      step();

      // 6: mask change in REQ, then reset mid-request
      reg_write(2'd1, 16'h0005);
      pulse(4'b0001);
      step();
      chk("t6_req", 32'(bus.int_req), 32'd1);
      reg_write(2'd1, 16'h0000);
      chk("t6_req_kept", 32'(bus.int_req), 32'd1);
      chk("t6_id_kept", 32'(bus.int_id), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_rst_req", 32'(bus.int_req), 32'd0);
      reg_read(2'd0, rd); chk("t6_rst_status", 32'(rd), 32'h0);
      reg_read(2'd1, rd); chk("t6_rst_mask", 32'(rd), 32'hF);
      reg_read(2'd3, rd); chk("t6_rst_eoi_rd", 32'(rd), 32'h0);
      step();
      chk("t6_no_rereq", 32'(bus.int_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
